// File: rtl/uart_rx_fifo_pkg.sv
// Shared types for the UART receive FIFO: handshake FSM states and default depth.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      WAIT_LO
   } rx_state_t;

   localparam int RX_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_fifo_rise_detect.sv
// Rising-edge detector: one-cycle pulse on the first cycle a level input is seen high.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) r_prev <= 1'b0;
      else       r_prev <= in;
   end

   assign pulse = in & ~r_prev;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: acknowledges bytes from the UART with a one-cycle rxclk and
// queues them; a pushbutton pops the head. UART_RX_FIFO_DROP_EN acks and drops when full.
//
// state   | meaning
// IDLE    | waiting for rxready; captures the byte if there is room
// ACK     | rxclk high for this single cycle
// WAIT_LO | waiting for the UART to drop rxready
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = RX_DEPTH_DEFAULT,
   parameter int WIDTH = 8
) (
   input  logic                     hz100,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         rxdata,
   input  logic                     rxready,
   output logic                     rxclk,
   input  logic                     pop_btn,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   rx_state_t        r_state;
   rx_state_t        w_state_nxt;
   logic             r_rxclk;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_push;
   logic             w_pop;
   logic             w_pop_edge;
`ifdef UART_RX_FIFO_DROP_EN
   logic             w_drop;
   logic             r_overflow;
`endif

   rise_detect u_pop_edge (
      .clk   (hz100),
      .reset (reset),
      .in    (pop_btn),
      .pulse (w_pop_edge)
   );

   assign empty = (r_count == '0);
   assign full  = (r_count == FULL_CNT);
   assign count = r_count;
   assign rxclk = r_rxclk;
   assign dout  = empty ? '0 : r_mem[r_rd_ptr];
   assign w_pop = w_pop_edge & ~empty;

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
`ifdef UART_RX_FIFO_DROP_EN
      w_drop      = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // full is the pre-pop occupancy, so a same-cycle pop never admits a push
            if (rxready) begin
               if (!full) begin
                  w_push      = 1'b1;
                  w_state_nxt = ACK;
               end
`ifdef UART_RX_FIFO_DROP_EN
               else begin
                  w_drop      = 1'b1;
                  w_state_nxt = ACK;
               end
`endif
            end
         end
         ACK:     w_state_nxt = WAIT_LO;
         WAIT_LO: if (!rxready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge hz100) begin
      if (reset) begin
         r_state  <= IDLE;
         r_rxclk  <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rxclk <= (w_state_nxt == ACK);
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge hz100) begin
      if (w_push && !reset) r_mem[r_wr_ptr] <= rxdata;
   end

`ifdef UART_RX_FIFO_DROP_EN
   always_ff @(posedge hz100) begin
      if (reset)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
   end
   assign overflow = r_overflow;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted bytes are queued, a monitor checks dout on each pop.
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;

   logic       hz100 = 1'b0;
   logic       reset;
   logic [7:0] rxdata;
   logic       rxready;
   logic       rxclk;
   logic       pop_btn;
   logic [7:0] dout;
   logic [3:0] count;
   logic       empty;
   logic       full;
   logic       overflow;

   int         total = 0;
   int         bad = 0;
   int         ack_cnt = 0;
   logic [7:0] exp_q[$];
   logic       prev_pop = 1'b0;

`ifdef UART_RX_FIFO_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
      .hz100    (hz100),
      .reset    (reset),
      .rxdata   (rxdata),
      .rxready  (rxready),
      .rxclk    (rxclk),
      .pop_btn  (pop_btn),
      .dout     (dout),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .overflow (overflow)
   );

   always #5 hz100 = ~hz100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts rxclk pulses and checks the head byte on each effective pop.
   always @(negedge hz100) begin
      if (rxclk === 1'b1) ack_cnt++;
      if (pop_btn && !prev_pop && !reset && exp_q.size() > 0)
         chk("pop_dout", {24'h0, dout}, {24'h0, exp_q.pop_front()});
      prev_pop = pop_btn;
   end

   task automatic chk_occ(input string tag);
      chk({tag, "_count"}, {28'h0, count}, exp_q.size());
      chk({tag, "_empty"}, {31'h0, empty}, {31'h0, exp_q.size() == 0});
      chk({tag, "_full"},  {31'h0, full},  {31'h0, exp_q.size() == DEPTH});
   endtask

   task automatic send(input logic [7:0] b, input bit accept, input bit expect_ack);
      int a0;
      bit seen;
      @(posedge hz100); #1;
      a0      = ack_cnt;
      rxdata  = b;
      rxready = 1'b1;
      if (accept) exp_q.push_back(b);
      seen = 1'b0;
      if (expect_ack) begin
         for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge hz100);
            if (rxclk) seen = 1'b1;
         end
         chk("ack_seen", {31'h0, seen}, 32'd1);
         @(posedge hz100); #1 rxready = 1'b0;
         @(posedge hz100); #1;
         chk("ack_once", ack_cnt - a0, 32'd1);
      end else begin
         repeat (4) @(posedge hz100);
         #1;
         chk("no_ack", ack_cnt - a0, 32'd0);
         rxready = 1'b0;
      end
   endtask

   task automatic pop1();
      @(posedge hz100); #1 pop_btn = 1'b1;
      @(posedge hz100); #1 pop_btn = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int  a0;
      bit  seen;
      reset   = 1'b1;
      rxready = 1'b0;
      rxdata  = 8'h00;
      pop_btn = 1'b0;
      repeat (3) @(posedge hz100);
      #1;
      chk("rst_rxclk",    {31'h0, rxclk},    32'd0);
      chk("rst_count",    {28'h0, count},    32'd0);
      chk("rst_empty",    {31'h0, empty},    32'd1);
      chk("rst_full",     {31'h0, full},     32'd0);
      chk("rst_overflow", {31'h0, overflow}, 32'd0);
      chk("rst_dout",     {24'h0, dout},     32'd0);
      reset = 1'b0;

      // 1: rxready held 3 cycles gives exactly one ack
      @(posedge hz100); #1;
      a0 = ack_cnt;
      rxdata = 8'hA5; rxready = 1'b1;
      exp_q.push_back(8'hA5);
      repeat (3) @(posedge hz100);
      #1 rxready = 1'b0;
      repeat (3) @(posedge hz100);
      #1;
      chk("t1_acks",  ack_cnt - a0, 32'd1);
      chk("t1_dout",  {24'h0, dout}, 32'h0000_00A5);
      chk_occ("t1");
      pop1();
      @(posedge hz100); #1;
      chk_occ("t1_pop");

      // 2: fill, then a ninth byte
      for (int i = 1; i <= 8; i++) send(8'(i), 1'b1, 1'b1);
      chk_occ("t2_fill");
      send(8'h09, 1'b0, DROP);
      chk("t2_overflow", {31'h0, overflow}, {31'h0, DROP});
      chk("t2_dout",     {24'h0, dout}, 32'h0000_0001);
      chk_occ("t2_after9");

      // 3: drain, then pop while empty
      repeat (8) pop1();
      @(posedge hz100); #1;
      chk("t3_dout_empty", {24'h0, dout}, 32'd0);
      chk_occ("t3_drained");
      pop1();
      @(posedge hz100); #1;
      chk_occ("t3_pop_empty");

      // 4: pointer wrap
      for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1, 1'b1);
      repeat (5) pop1();
      for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), 1'b1, 1'b1);
      @(posedge hz100); #1;
      chk_occ("t4_six");
      repeat (6) pop1();
      @(posedge hz100); #1;
      chk_occ("t4_end");

      // held button pops once
      send(8'h40, 1'b1, 1'b1);
      send(8'h41, 1'b1, 1'b1);
      @(posedge hz100); #1 pop_btn = 1'b1;
      repeat (5) @(posedge hz100);
      #1;
      chk("hold_count", {28'h0, count}, 32'd1);
      pop_btn = 1'b0;
      pop1();
      @(posedge hz100); #1;
      chk_occ("hold_end");

      // 5: simultaneous push and pop at count 3
      send(8'h30, 1'b1, 1'b1);
      send(8'h31, 1'b1, 1'b1);
      send(8'h32, 1'b1, 1'b1);
      @(posedge hz100); #1;
      a0 = ack_cnt;
      rxdata = 8'h33; rxready = 1'b1; pop_btn = 1'b1;
      exp_q.push_back(8'h33);
      @(posedge hz100); #1;
      chk("t5_count3", {28'h0, count}, 32'd3);
      chk("t5_head",   {24'h0, dout},  32'h0000_0031);
      pop_btn = 1'b0;
      @(posedge hz100); #1 rxready = 1'b0;
      @(posedge hz100); #1;
      chk("t5_ack", ack_cnt - a0, 32'd1);
      for (int i = 0; i < 5; i++) send(8'h34 + 8'(i), 1'b1, 1'b1);
      chk_occ("t5_full");

      // 5b: simultaneous at count 8: pop happens, push does not
      @(posedge hz100); #1;
      a0 = ack_cnt;
      rxdata = 8'h39; rxready = 1'b1; pop_btn = 1'b1;
      @(posedge hz100); #1;
      rxready = 1'b0; pop_btn = 1'b0;
      chk("t5b_count7", {28'h0, count}, 32'd7);
      repeat (3) @(posedge hz100);
      #1;
      chk("t5b_acks",     ack_cnt - a0, {31'h0, DROP});
      chk("t5b_overflow", {31'h0, overflow}, {31'h0, DROP});
      chk_occ("t5b");
      repeat (7) pop1();
      @(posedge hz100); #1;
      chk_occ("t5b_drain");

      // 6: reset during ACK, then re-capture of the still-present byte
      @(posedge hz100); #1;
      rxdata = 8'h5A; rxready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge hz100);
         if (rxclk) seen = 1'b1;
      end
      chk("t6_ack_seen", {31'h0, seen}, 32'd1);
      reset = 1'b1;
      @(posedge hz100); #1;
      reset = 1'b0;
      exp_q.delete();
      a0 = ack_cnt;
      chk("t6_rxclk",    {31'h0, rxclk},    32'd0);
      chk("t6_count",    {28'h0, count},    32'd0);
      chk("t6_overflow", {31'h0, overflow}, 32'd0);
      exp_q.push_back(8'h5A);
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge hz100);
         if (rxclk) seen = 1'b1;
      end
      chk("t6_reack_seen", {31'h0, seen}, 32'd1);
      @(posedge hz100); #1 rxready = 1'b0;
      repeat (3) @(posedge hz100);
      #1;
      chk("t6_reack_once", ack_cnt - a0, 32'd1);
      chk("t6_dout",       {24'h0, dout}, 32'h0000_005A);
      chk_occ("t6");
      pop1();
      @(posedge hz100); #1;
      chk_occ("t6_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
